aes_stream_io: RTL and testbench

// - Word-stream front/back end for the AES round iterator. Packs 32-bit input words into a 128-bit

---
 rtl/aes_stream_io_pkg.sv | 22 ++
 rtl/aes_word_ser.sv | 37 +++
 rtl/aes_stream_io.sv | 120 ++++++++++++
 tb/tb_aes_stream_io.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_io_pkg.sv
// Shared definitions for the AES word-stream front/back end: state encodings,
// block/word geometry and the word-slot helper used for packing and unpacking.
package aes_stream_io_pkg;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;

    localparam logic [1:0] IDX_FIRST = 2'd0;
    localparam logic [1:0] IDX_LAST  = 2'd3;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    // Slot 0 is the most significant word of the block.
    function automatic logic [6:0] word_lo(input logic [1:0] idx);
        return 7'(BLOCK_W - WORD_W) - {idx, 5'd0};
    endfunction

endpackage

// File: rtl/aes_word_ser.sv
// 128-bit block to four 32-bit words over valid/ready; most significant word first.
module aes_word_ser
    import aes_stream_io_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [BLOCK_W-1:0] block,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last
);

    logic [BLOCK_W-1:0] blk;
    logic [1:0]         idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk       <= '0;
            idx       <= IDX_FIRST;
            out_valid <= 1'b0;
        end else if (load) begin
            blk       <= block;
            idx       <= IDX_FIRST;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            if (idx == IDX_LAST) out_valid <= 1'b0;
            else                 idx       <= idx + 2'd1;
        end
    end

    // Word and last flag come straight from held state, so they stay put under backpressure.
    assign out_data = blk[word_lo(idx) +: WORD_W];
    assign out_last = out_valid && (idx == IDX_LAST);

endmodule

// File: rtl/aes_stream_io.sv
// Word-stream wrapper around the AES round core: packs plaintext/key words,
// starts the core, watches for a stuck core and streams the result back out.
module aes_stream_io
    import aes_stream_io_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sel,
    input  logic [WORD_W-1:0]  in_data,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_in,
    output logic [BLOCK_W-1:0] core_key,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last,
    output logic               key_loaded,
    output logic               err
);

    state_t          state;
    logic [1:0]      dcnt;
    logic [1:0]      kcnt;
    logic            data_full;
    logic [TO_W-1:0] tcnt;

    logic in_fire;
    logic ser_load;
    logic drain_end;

    // A complete data group waiting on its key blocks further data but still takes key words.
    assign in_ready  = (state == ST_LOAD) && (!data_full || in_sel);
    assign in_fire   = in_valid && in_ready;
    assign ser_load  = (state == ST_RUN) && core_done;
    assign drain_end = out_valid && out_ready && out_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOAD;
            dcnt       <= IDX_FIRST;
            kcnt       <= IDX_FIRST;
            data_full  <= 1'b0;
            tcnt       <= '0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
            core_start <= 1'b0;
            core_in    <= '0;
            core_key   <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (in_fire && !in_sel) begin
                        core_in[word_lo(dcnt) +: WORD_W] <= in_data;
                        dcnt <= dcnt + 2'd1;
                        if (dcnt == IDX_LAST) begin
                            if (key_loaded) begin
                                state      <= ST_RUN;
                                core_start <= 1'b1;
                                tcnt       <= '0;
                            end else begin
                                data_full <= 1'b1;
                            end
                        end
                    end else if (in_fire && in_sel) begin
                        core_key[word_lo(kcnt) +: WORD_W] <= in_data;
                        kcnt <= kcnt + 2'd1;
                        if (kcnt == IDX_FIRST) key_loaded <= 1'b0;
                        if (kcnt == IDX_LAST) begin
                            key_loaded <= 1'b1;
                            if (data_full) begin
                                data_full  <= 1'b0;
                                state      <= ST_RUN;
                                core_start <= 1'b1;
                                tcnt       <= '0;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    // A done on the expiry cycle still counts as success.
                    if (core_done) begin
                        state <= ST_DRAIN;
                        tcnt  <= '0;
                    end else if (tcnt == TO_W'(TIMEOUT)) begin
                        err   <= 1'b1;
                        dcnt  <= IDX_FIRST;
                        state <= ST_LOAD;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_end) state <= ST_LOAD;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    aes_word_ser u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .block     (core_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_aes_stream_io.sv
// Scoreboard bench for aes_stream_io: directed FIPS-197 vectors, a behavioural core,
// backpressure, hold-for-key, timeout and reset cases.
module tb_aes_stream_io;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sel = 1'b0;
    logic [31:0]  in_data = '0;
    logic         core_start;
    logic [127:0] core_in;
    logic [127:0] core_key;
    logic         core_done = 1'b0;
    logic [127:0] core_out = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic         out_last;
    logic         key_loaded;
    logic         err;

    aes_stream_io #(.TIMEOUT(64), .TO_W(7)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .core_start(core_start), .core_in(core_in), .core_key(core_key),
        .core_done(core_done), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .key_loaded(key_loaded), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic last; } ow_t;
    typedef struct { logic [127:0] pt; logic [127:0] key; } st_t;

    ow_t exp_out[$];
    st_t exp_start[$];

    int n_cmp = 0;
    int n_bad = 0;

    int           core_lat = 0;
    logic [127:0] model_ct = '0;
    logic         toggle_rdy = 1'b0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'hfedcba98765432100f1e2d3c4b5a6978;
    localparam logic [127:0] CT2  = 128'hdeadbeef0123456789abcdefcafef00d;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT3  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT3  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT4  = 128'h11111111222222223333333344444444;
    localparam logic [127:0] CT4  = 128'haaaaaaaabbbbbbbbccccccccdddddddd;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Behavioural core: done pulses core_lat cycles after the start pulse; 0 means never.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (core_start && core_lat != 0) begin
                repeat (core_lat) @(posedge clk);
                #1 core_done = 1'b1; core_out = model_ct;
                @(posedge clk);
                #1 core_done = 1'b0; core_out = 128'h0bad;
            end
        end
    end

    // Backpressure pattern 1,0,0,1 when enabled, else always ready.
    initial begin
        int i = 0;
        forever begin
            @(posedge clk); #2;
            if (toggle_rdy) begin
                out_ready = (i % 4 == 0) || (i % 4 == 3);
                i++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Output monitor: pops expected words on handshake, checks hold under stall.
    initial begin
        logic        held = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        ow_t         e;
        forever begin
            @(negedge clk);
            if (held && out_valid) begin
                chk("stall_data_hold", {96'd0, out_data}, {96'd0, held_d});
                chk("stall_last_hold", {127'd0, out_last}, {127'd0, held_l});
            end
            held = reset && out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (reset && out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_unexpected: got %h with no word expected", out_data);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_data", {96'd0, out_data}, {96'd0, e.d});
                    chk("out_last", {127'd0, out_last}, {127'd0, e.last});
                end
            end
        end
    end

    // Start monitor: one-cycle pulse carrying the expected block and key.
    initial begin
        logic prev = 1'b0;
        st_t  s;
        forever begin
            @(negedge clk);
            if (core_start) begin
                chk("start_one_cycle", {127'd0, prev}, 128'd0);
                if (!prev) begin
                    if (exp_start.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL start_unexpected: got core_in %h with no start expected", core_in);
                    end else begin
                        s = exp_start.pop_front();
                        chk("core_in", core_in, s.pt);
                        chk("core_key", core_key, s.key);
                    end
                end
            end
            prev = core_start;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish want finish before 50000ns");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic sel, input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1; in_sel = sel; in_data = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin n++; @(negedge clk); end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got in_ready 0 want 1 (sel %0d)", sel);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic sel, input logic [127:0] v);
        for (int i = 0; i < 4; i++) send(sel, v[127-32*i -: 32]);
    endtask

    task automatic push_out(input logic [127:0] ct);
        for (int i = 0; i < 4; i++) exp_out.push_back('{ct[127-32*i -: 32], (i == 3)});
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_out.size() != 0 && n < 400) begin n++; @(posedge clk); end
        if (exp_out.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_drain_timeout: got %0d words pending want 0", nm, exp_out.size());
        end
        repeat (2) @(posedge clk); #1;
        in_sel = 1'b0; #1;
        chk({nm, "_out_valid_idle"}, {127'd0, out_valid}, 128'd0);
        chk({nm, "_back_to_load"}, {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        int n;
        // Reset values
        #23;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_core_start", {127'd0, core_start}, 128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_last", {127'd0, out_last}, 128'd0);
        chk("rst_key_loaded", {127'd0, key_loaded}, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);
        chk("rst_core_in", core_in, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_out_data", {96'd0, out_data}, 128'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 C.1 block, key first
        core_lat = 10; model_ct = CT1;
        exp_start.push_back('{PT1, KEY1}); push_out(CT1);
        send_block(1'b1, KEY1);
        chk("b1_key_loaded", {127'd0, key_loaded}, 128'd1);
        send_block(1'b0, PT1);
        chk("b1_start_latency", {127'd0, core_start}, 128'd1);
        wait_drain("b1");

        // Key reused, output backpressure 1,0,0,1
        model_ct = CT2; toggle_rdy = 1'b1;
        exp_start.push_back('{PT2, KEY1}); push_out(CT2);
        send_block(1'b0, PT2);
        chk("b2_start_latency", {127'd0, core_start}, 128'd1);
        wait_drain("b2");
        toggle_rdy = 1'b0;

        // Data group complete before the new key: held until the 4th key word
        model_ct = CT3;
        exp_start.push_back('{PT3, KEY2}); push_out(CT3);
        send(1'b1, KEY2[127:96]);
        chk("b3_key_dropped", {127'd0, key_loaded}, 128'd0);
        send_block(1'b0, PT3);
        chk("b3_held_no_start", {127'd0, core_start}, 128'd0);
        in_sel = 1'b0; #1;
        chk("b3_data_stalled", {127'd0, in_ready}, 128'd0);
        in_sel = 1'b1; #1;
        chk("b3_key_open", {127'd0, in_ready}, 128'd1);
        send(1'b1, KEY2[95:64]);
        send(1'b1, KEY2[63:32]);
        send(1'b1, KEY2[31:0]);
        chk("b3_start_after_key", {127'd0, core_start}, 128'd1);
        wait_drain("b3");

        // core_done exactly on the expiry cycle
        core_lat = 64; model_ct = CT4;
        exp_start.push_back('{PT4, KEY2}); push_out(CT4);
        send_block(1'b0, PT4);
        wait_drain("b4");
        chk("b4_no_err", {127'd0, err}, 128'd0);

        // Core never answers
        core_lat = 0;
        exp_start.push_back('{PT1, KEY2});
        send_block(1'b0, PT1);
        n = 0;
        while (!err && n < 200) begin @(posedge clk); #1; n++; end
        chk("to_cycles", 128'(n), 128'd65);
        in_sel = 1'b0; #1;
        chk("to_in_ready", {127'd0, in_ready}, 128'd1);
        chk("to_key_kept", {127'd0, key_loaded}, 128'd1);
        chk("to_out_valid", {127'd0, out_valid}, 128'd0);

        // Reset in the middle of RUN
        exp_start.push_back('{PT2, KEY2});
        send_block(1'b0, PT2);
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("mid_rst_core_start", {127'd0, core_start}, 128'd0);
        chk("mid_rst_key_loaded", {127'd0, key_loaded}, 128'd0);
        chk("mid_rst_err", {127'd0, err}, 128'd0);
        chk("mid_rst_core_in", core_in, 128'd0);
        chk("mid_rst_core_key", core_key, 128'd0);
        chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        @(negedge clk); reset = 1'b1;

        // Spurious core_done in LOAD is ignored
        @(posedge clk); #1 core_done = 1'b1; core_out = CT1;
        @(posedge clk); #1 core_done = 1'b0;
        @(posedge clk); #1;
        chk("spurious_out_valid", {127'd0, out_valid}, 128'd0);
        chk("spurious_in_ready", {127'd0, in_ready}, 128'd1);

        chk("exp_out_empty", 128'(exp_out.size()), 128'd0);
        chk("exp_start_empty", 128'(exp_start.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
